// File: rtl/xreg_wb_arbiter.sv
// xreg_wb_arbiter: round-robin ALU/LSU writeback arbiter with a register-file busy scoreboard.
module xreg_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            aluValid,
    output logic            aluReady,
    input  logic [4:0]      aluRd,
    input  logic [XLEN-1:0] aluData,
    input  logic            lsuValid,
    output logic            lsuReady,
    input  logic [4:0]      lsuRd,
    input  logic [XLEN-1:0] lsuData,
    output logic            writeEnable,
    output logic [4:0]      writeAddr,
    output logic [XLEN-1:0] writeData,
    input  logic            issueValid,
    input  logic [4:0]      issueRd,
    output logic            issueStall,
    input  logic [4:0]      queryAddr1,
    input  logic [4:0]      queryAddr2,
    output logic            busy1,
    output logic            busy2
);
    logic [31:1] busy;
    logic [31:0] busyVec;
    logic        lastGrant;
    logic        grantLsu;
    logic        xfer;
    logic [4:0]  xferRd;
    logic        issueOk;
    logic [31:1] setMask;
    logic [31:1] clrMask;

    assign busyVec    = {busy, 1'b0};
    assign busy1      = busyVec[queryAddr1];
    assign busy2      = busyVec[queryAddr2];
    assign issueStall = issueValid && issueRd != 5'd0 && busyVec[issueRd];
    assign issueOk    = issueValid && !issueStall && issueRd != 5'd0 && !flush;
    // lastGrant: 0 = ALU granted last (LSU wins next contention), 1 = LSU
    assign grantLsu   = lsuValid && (!aluValid || !lastGrant);
    assign lsuReady   = rst_n && !flush && grantLsu;
    assign aluReady   = rst_n && !flush && aluValid && !grantLsu;
    assign xfer       = aluReady || lsuReady;
    assign xferRd     = lsuReady ? lsuRd : aluRd;
    assign setMask    = issueOk ? (31'(1) << (issueRd - 5'd1)) : 31'd0;
    assign clrMask    = writeEnable ? (31'(1) << (writeAddr - 5'd1)) : 31'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            lastGrant   <= 1'b0;
            writeEnable <= 1'b0;
            writeAddr   <= '0;
            writeData   <= '0;
        end else begin
            busy        <= flush ? '0 : ((busy & ~clrMask) | setMask);
            writeEnable <= xfer && xferRd != 5'd0;
            if (xfer) begin
                lastGrant <= lsuReady;
                writeAddr <= xferRd;
                writeData <= lsuReady ? lsuData : aluData;
            end
        end
    end
endmodule
